// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the skid-slice pipeline chain.
package pipe_pkg;

   localparam logic [1:0] SLICE_E = 2'd0;
   localparam logic [1:0] SLICE_M = 2'd1;
   localparam logic [1:0] SLICE_F = 2'd2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/pipe_skid_slice.sv
// One 2-entry skid register slice: main register drives the output, skid absorbs
// the single beat that arrives while downstream stalls. Ready and data are both registered.
module pipe_skid_slice
   import pipe_pkg::*;
#(
   parameter int DATA_WD = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [DATA_WD-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_WD-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [1:0]         state;
   logic [DATA_WD-1:0] main_q;
   logic [DATA_WD-1:0] skid_q;
   logic               acc;
   logic               fire;

   // Ready/valid are pure decodes of the state register, so no input reaches them.
   assign in_ready  = (state != SLICE_F);
   assign out_valid = (state != SLICE_E);
   assign out_data  = main_q;

   assign acc  = in_valid & in_ready & ~flush;
   assign fire = out_valid & out_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= SLICE_E;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state <= SLICE_E;
      end else begin
         case (state)
            SLICE_E: begin
               if (acc) begin
                  state  <= SLICE_M;
                  main_q <= in_data;
               end
            end
            SLICE_M: begin
               if (acc && !fire) begin
                  state  <= SLICE_F;
                  skid_q <= in_data;
               end else if (acc && fire) begin
                  main_q <= in_data;
               end else if (!acc && fire) begin
                  state <= SLICE_E;
               end
            end
            SLICE_F: begin
               if (fire) begin
                  state  <= SLICE_M;
                  main_q <= skid_q;
               end
            end
            default: state <= SLICE_E;
         endcase
      end
   end

endmodule

// File: rtl/pipe_skid_chain.sv
// DEPTH cascaded skid slices with synchronous flush.
// Define PIPE_OCC_EN to add the occ port (beats currently held in the chain).
module pipe_skid_chain
   import pipe_pkg::*;
#(
   parameter int DATA_WD = 32,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [DATA_WD-1:0] din,
   input  logic               pre_valid,
   output logic               cur_ready,
   output logic [DATA_WD-1:0] dout,
   output logic               cur_valid,
   input  logic               nxt_ready
`ifdef PIPE_OCC_EN
   ,
   output logic [clog2(2*DEPTH+1)-1:0] occ
`endif
);

   logic [DEPTH:0][DATA_WD-1:0] dat;
   logic [DEPTH:0]              vld;
   logic [DEPTH:0]              rdy;

   assign dat[0]     = din;
   assign vld[0]     = pre_valid;
   assign rdy[DEPTH] = nxt_ready;

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_slice
         pipe_skid_slice #(.DATA_WD(DATA_WD)) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_data   (dat[g]),
            .in_valid  (vld[g]),
            .in_ready  (rdy[g]),
            .out_data  (dat[g+1]),
            .out_valid (vld[g+1]),
            .out_ready (rdy[g+1])
         );
      end
   endgenerate

   // Flush masks both external handshakes so nothing transfers in the flush cycle.
   assign cur_ready = rdy[0] & ~flush;
   assign cur_valid = vld[DEPTH] & ~flush;
   assign dout      = dat[DEPTH];

`ifdef PIPE_OCC_EN
   localparam int OCC_W = clog2(2*DEPTH+1);

   logic acc;
   logic emit;

   assign acc  = pre_valid & cur_ready;
   assign emit = cur_valid & nxt_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ <= '0;
      end else if (flush) begin
         occ <= '0;
      end else if (acc && !emit) begin
         occ <= occ + OCC_W'(1);
      end else if (!acc && emit) begin
         occ <= occ - OCC_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Bench: DEPTH=3 and DEPTH=2 chains share stimulus; each is scored against a FIFO model.
module tb_pipe_skid_chain;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [31:0] din;
   logic        pre_valid;
   logic        nxt_ready;
   logic        cr [2];
   logic        cv [2];
   logic [31:0] dq [2];
   logic [2:0]  oc [2];

   int D [2] = '{3, 2};

   pipe_skid_chain #(.DATA_WD(32), .DEPTH(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .pre_valid(pre_valid),
      .cur_ready(cr[0]), .dout(dq[0]), .cur_valid(cv[0]), .nxt_ready(nxt_ready)
`ifdef PIPE_OCC_EN
      , .occ(oc[0])
`endif
   );

   pipe_skid_chain #(.DATA_WD(32), .DEPTH(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .pre_valid(pre_valid),
      .cur_ready(cr[1]), .dout(dq[1]), .cur_valid(cv[1]), .nxt_ready(nxt_ready)
`ifdef PIPE_OCC_EN
      , .occ(oc[1])
`endif
   );

`ifndef PIPE_OCC_EN
   assign oc[0] = '0;
   assign oc[1] = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] sb0 [$];
   logic [31:0] sb1 [$];

   logic acc [2];
   logic emt [2];
   int   n_acc [2];
   int   n_emt [2];
   int   first_acc [2];
   int   last_acc [2];
   int   first_emt [2];
   int   last_emt [2];

   task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[d%0d] got=0x%0h exp=0x%0h (cyc %0d)", tag, D[inst], got, exp, cyc);
      end
   endtask

   function automatic int sz(input int i);
      return (i == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic logic [31:0] front(input int i);
      return (i == 0) ? sb0[0] : sb1[0];
   endfunction

   task automatic push(input int i, input logic [31:0] v);
      if (i == 0) sb0.push_back(v);
      else        sb1.push_back(v);
   endtask

   task automatic pop(input int i);
      if (i == 0) void'(sb0.pop_front());
      else        void'(sb1.pop_front());
   endtask

   task automatic clr_model();
      sb0.delete();
      sb1.delete();
   endtask

   task automatic clr_stats();
      for (int i = 0; i < 2; i++) begin
         n_acc[i] = 0; n_emt[i] = 0;
         first_acc[i] = -1; last_acc[i] = -1;
         first_emt[i] = -1; last_emt[i] = -1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; pre_valid = 1'b0; nxt_ready = 1'b0; flush = 1'b0; din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clr_model();
      clr_stats();
   endtask

   // One cycle: drive at negedge, observe the handshake the next posedge will commit.
   task automatic step(input logic pv, input logic [31:0] d, input logic nr, input logic fl);
      logic crs [2];
      @(negedge clk);
      pre_valid = pv; din = d; nxt_ready = nr; flush = fl;
      #1;
      crs = cr;
      nxt_ready = ~nr;
      #1;
      for (int i = 0; i < 2; i++) chk("rdy_indep", i, 32'(cr[i]), 32'(crs[i]));
      nxt_ready = nr;
      #1;
      for (int i = 0; i < 2; i++) begin
`ifdef PIPE_OCC_EN
         chk("occ_model", i, 32'(oc[i]), 32'(sz(i)));
`endif
         acc[i] = pv & cr[i];
         emt[i] = cv[i] & nr;
         if (emt[i]) begin
            chk("emit_nonempty", i, 32'(sz(i) != 0), 32'd1);
            if (sz(i) != 0) begin
               chk("order", i, dq[i], front(i));
               pop(i);
            end
            n_emt[i]++;
            if (first_emt[i] < 0) first_emt[i] = cyc;
            last_emt[i] = cyc;
         end
         if (acc[i]) begin
            push(i, d);
            n_acc[i]++;
            if (first_acc[i] < 0) first_acc[i] = cyc;
            last_acc[i] = cyc;
         end
         chk("capacity", i, 32'(sz(i) <= 2*D[i]), 32'd1);
      end
      cyc++;
   endtask

   initial begin
      int guard;
      rst_n = 1'b1; flush = 1'b0; din = '0; pre_valid = 1'b0; nxt_ready = 1'b0;
      clr_stats();

      // reset state
      do_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", i, 32'(cv[i]), 32'd0);
         chk("rst_dout", i, dq[i], 32'd0);
         chk("rst_ready", i, 32'(cr[i]), 32'd1);
`ifdef PIPE_OCC_EN
         chk("rst_occ", i, 32'(oc[i]), 32'd0);
`endif
      end

      // 1: streaming latency and gap-free throughput
      clr_stats();
      for (int k = 1; k <= 16; k++) step(1'b1, 32'(k), 1'b1, 1'b0);
      repeat (8) step(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("s1_acc", i, 32'(n_acc[i]), 32'd16);
         chk("s1_emt", i, 32'(n_emt[i]), 32'd16);
         chk("s1_latency", i, 32'(first_emt[i] - first_acc[i]), 32'(D[i]));
         chk("s1_nogap", i, 32'(last_emt[i] - first_emt[i]), 32'd15);
      end

      // 2: fill under backpressure, then drain
      do_reset();
      repeat (10) step(1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("s2_fill", i, 32'(n_acc[i]), 32'(2*D[i]));
         chk("s2_contig", i, 32'(last_acc[i] - first_acc[i]), 32'(2*D[i]-1));
         chk("s2_full_rdy", i, 32'(cr[i]), 32'd0);
      end
      clr_stats();
      repeat (8) step(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("s2_drain", i, 32'(n_emt[i]), 32'(2*D[i]));
         chk("s2_empty", i, 32'(sz(i)), 32'd0);
      end

      // 3: random valid/ready traffic
      do_reset();
      guard = 0;
      while (n_emt[1] < 10000 && guard < 60000) begin
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         guard++;
      end
      chk("s3_done", 1, 32'(n_emt[1] >= 10000), 32'd1);
      repeat (12) step(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("s3_drained", i, 32'(sz(i)), 32'd0);
         chk("s3_count", i, 32'(n_emt[i]), 32'(n_acc[i]));
      end

      // 4: flush with beats held
      do_reset();
      repeat (3) step(1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) chk("s4_held", i, 32'(n_acc[i]), 32'd3);
      step(1'b1, $urandom, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk("s4_flush_rdy", i, 32'(cr[i]), 32'd0);
         chk("s4_flush_vld", i, 32'(cv[i]), 32'd0);
      end
      clr_model();
      step(1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("s4_post_vld", i, 32'(cv[i]), 32'd0);
         chk("s4_post_rdy", i, 32'(cr[i]), 32'd1);
`ifdef PIPE_OCC_EN
         chk("s4_post_occ", i, 32'(oc[i]), 32'd0);
`endif
      end

      // 5: asynchronous reset mid-stream
      do_reset();
      repeat (5) step(1'b1, $urandom, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) chk("s5_streaming", i, 32'(cv[i]), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("s5_async_vld", i, 32'(cv[i]), 32'd0);
         chk("s5_async_dout", i, dq[i], 32'd0);
      end
      clr_model();
      pre_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clr_stats();
      step(1'b1, 32'hA5, 1'b1, 1'b0);
      repeat (5) step(1'b0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("s5_one_out", i, 32'(n_emt[i]), 32'd1);
         chk("s5_latency", i, 32'(first_emt[i] - first_acc[i]), 32'(D[i]));
      end

`ifdef PIPE_OCC_EN
      // 6: occupancy under balanced flow and when full
      do_reset();
      repeat (2) step(1'b1, $urandom, 1'b0, 1'b0);
      repeat (6) step(1'b0, 32'd0, 1'b0, 1'b0);
      repeat (8) begin
         step(1'b1, $urandom, 1'b1, 1'b0);
         chk("s6_flow", 1, 32'(acc[1] & emt[1]), 32'd1);
         chk("s6_occ2", 1, 32'(oc[1]), 32'd2);
      end
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk("s6_occ2_end", 1, 32'(oc[1]), 32'd2);
      repeat (8) step(1'b1, $urandom, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) chk("s6_occ_full", i, 32'(oc[i]), 32'(2*D[i]));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
